// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR trap sequencer: request op
// encodings, mapped CSR addresses, mstatus field positions, trap cause codes,
// csr_wen bit positions and the sequencer state type.
package csr_pkg;

  // Request op encodings (values 6 and 7 are illegal)
  localparam logic [2:0] OP_CSRRW  = 3'd0;
  localparam logic [2:0] OP_CSRRS  = 3'd1;
  localparam logic [2:0] OP_CSRRC  = 3'd2;
  localparam logic [2:0] OP_ECALL  = 3'd3;
  localparam logic [2:0] OP_EBREAK = 3'd4;
  localparam logic [2:0] OP_MRET   = 3'd5;

  // Mapped CSR addresses; everything else is illegal
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mcause values for synchronous exceptions
  localparam int CAUSE_ECALL_M    = 11;
  localparam int CAUSE_BREAKPOINT = 3;

  // csr_wen bit positions
  localparam int WEN_MEPC    = 0;
  localparam int WEN_MCAUSE  = 1;
  localparam int WEN_MSTATUS = 2;
  localparam int WEN_MTVEC   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/csr_alu.sv
// Combinational read-modify-write merge for CSRRW/CSRRS/CSRRC. Set/clear with a
// zero mask leaves the CSR untouched, signalled by write_en=0.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] new_val,
  output logic            write_en
);

  // Merge old value with operand according to the CSR instruction flavour
  always_comb begin
    new_val  = old_val;
    write_en = 1'b0;
    case (op)
      OP_CSRRW: begin
        new_val  = wdata;
        write_en = 1'b1;
      end
      OP_CSRRS: begin
        new_val  = old_val | wdata;
        write_en = |wdata;
      end
      OP_CSRRC: begin
        new_val  = old_val & ~wdata;
        write_en = |wdata;
      end
      default: begin
        new_val  = old_val;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR/trap sequencer sitting in front of the CSR register file.
// Each request is latched in IDLE, performs its CSR writes during the single
// EXEC cycle, and is reported in RESP until the consumer accepts it.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_csr_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN-1:0]   req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_redirect,
  output logic [XLEN-1:0]   resp_pc,
  output logic              resp_illegal,
  input  logic [XLEN-1:0]   mepc_out,
  input  logic [XLEN-1:0]   mcause_out,
  input  logic [XLEN-1:0]   mstatus_out,
  input  logic [XLEN-1:0]   mtvec_out,
  output logic [XLEN-1:0]   mepc_in,
  output logic [XLEN-1:0]   mcause_in,
  output logic [XLEN-1:0]   mstatus_in,
  output logic [XLEN-1:0]   mtvec_in,
  output logic [3:0]        csr_wen
);

  // Clears the two low bits: mepc and trap vectors are word aligned here
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, MPIE set, MPP stays M (only mode)
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  state_e              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN-1:0]     pc_q;

  logic                sel_mstatus, sel_mtvec, sel_mepc, sel_mcause, mapped;
  logic [XLEN-1:0]     old_val;
  logic [XLEN-1:0]     alu_new;
  logic                alu_we;

  logic [XLEN-1:0]     exec_rdata;
  logic                exec_redirect;
  logic [XLEN-1:0]     exec_pc;
  logic                exec_illegal;

  assign sel_mstatus = (addr_q == ADDR_W'(CSR_MSTATUS));
  assign sel_mtvec   = (addr_q == ADDR_W'(CSR_MTVEC));
  assign sel_mepc    = (addr_q == ADDR_W'(CSR_MEPC));
  assign sel_mcause  = (addr_q == ADDR_W'(CSR_MCAUSE));
  assign mapped      = sel_mstatus | sel_mtvec | sel_mepc | sel_mcause;

  // Current value of the addressed CSR, used for rd and as the RMW source
  always_comb begin
    old_val = '0;
    if (sel_mstatus) old_val = mstatus_out;
    if (sel_mtvec)   old_val = mtvec_out;
    if (sel_mepc)    old_val = mepc_out;
    if (sel_mcause)  old_val = mcause_out;
  end

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op       (op_q),
    .old_val  (old_val),
    .wdata    (wdata_q),
    .new_val  (alu_new),
    .write_en (alu_we)
  );

  // EXEC-cycle CSR write strobes/data and the response values to register
  always_comb begin
    csr_wen       = 4'b0000;
    mepc_in       = '0;
    mcause_in     = '0;
    mstatus_in    = '0;
    mtvec_in      = '0;
    exec_rdata    = '0;
    exec_redirect = 1'b0;
    exec_pc       = '0;
    exec_illegal  = 1'b0;
    if (state == ST_EXEC) begin
      // Unwritten CSRs see their own value on *_in, so a stray strobe is harmless
      mepc_in    = mepc_out;
      mcause_in  = mcause_out;
      mstatus_in = mstatus_out;
      mtvec_in   = mtvec_out;
      case (op_q)
        OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
          if (mapped) begin
            exec_rdata = old_val;
            if (sel_mepc)    mepc_in    = alu_new & ALIGN_MASK;
            if (sel_mcause)  mcause_in  = alu_new;
            if (sel_mstatus) mstatus_in = alu_new;
            if (sel_mtvec)   mtvec_in   = alu_new;
            csr_wen[WEN_MEPC]    = alu_we & sel_mepc;
            csr_wen[WEN_MCAUSE]  = alu_we & sel_mcause;
            csr_wen[WEN_MSTATUS] = alu_we & sel_mstatus;
            csr_wen[WEN_MTVEC]   = alu_we & sel_mtvec;
          end else begin
            exec_illegal = 1'b1;
          end
        end
        OP_ECALL, OP_EBREAK: begin
          mepc_in    = pc_q & ALIGN_MASK;
          mcause_in  = (op_q == OP_ECALL) ? XLEN'(CAUSE_ECALL_M) : XLEN'(CAUSE_BREAKPOINT);
          mstatus_in = trap_mstatus(mstatus_out);
          csr_wen[WEN_MEPC]    = 1'b1;
          csr_wen[WEN_MCAUSE]  = 1'b1;
          csr_wen[WEN_MSTATUS] = 1'b1;
          exec_redirect = 1'b1;
          exec_pc       = mtvec_out & ALIGN_MASK;
        end
        OP_MRET: begin
          mstatus_in = mret_mstatus(mstatus_out);
          csr_wen[WEN_MSTATUS] = 1'b1;
          exec_redirect = 1'b1;
          exec_pc       = mepc_out;
        end
        default: begin
          exec_illegal = 1'b1;
        end
      endcase
    end
  end

  // Sequencer FSM with request latches and registered handshake/response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_redirect <= 1'b0;
      resp_pc       <= '0;
      resp_illegal  <= 1'b0;
      op_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pc_q          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_q    <= req_csr_addr;
            wdata_q   <= req_wdata;
            pc_q      <= req_pc;
            req_ready <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_rdata    <= exec_rdata;
          resp_redirect <= exec_redirect;
          resp_pc       <= exec_pc;
          resp_illegal  <= exec_illegal;
          resp_valid    <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: a behavioural CSR file closes the loop,
// stimulus pushes hand-computed responses, a monitor pops them on handshake.
module tb_csr_trap_ctrl;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_csr_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN-1:0]   req_pc;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_redirect;
  logic [XLEN-1:0]   resp_pc;
  logic              resp_illegal;
  logic [XLEN-1:0]   mepc_out, mcause_out, mstatus_out, mtvec_out;
  logic [XLEN-1:0]   mepc_in, mcause_in, mstatus_in, mtvec_in;
  logic [3:0]        csr_wen;

  csr_trap_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_addr(req_csr_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_pc(resp_pc), .resp_illegal(resp_illegal),
    .mepc_out(mepc_out), .mcause_out(mcause_out), .mstatus_out(mstatus_out),
    .mtvec_out(mtvec_out),
    .mepc_in(mepc_in), .mcause_in(mcause_in), .mstatus_in(mstatus_in),
    .mtvec_in(mtvec_in),
    .csr_wen(csr_wen)
  );

  always #5 clk = ~clk;

  // Behavioural CSR register file (not reset by the sequencer's rst)
  logic [XLEN-1:0] m_mepc = '0, m_mcause = '0, m_mstatus = 32'h0000_1808, m_mtvec = '0;
  always @(posedge clk) begin
    if (csr_wen[0]) m_mepc    <= mepc_in;
    if (csr_wen[1]) m_mcause  <= mcause_in;
    if (csr_wen[2]) m_mstatus <= mstatus_in;
    if (csr_wen[3]) m_mtvec   <= mtvec_in;
  end
  assign mepc_out    = m_mepc;
  assign mcause_out  = m_mcause;
  assign mstatus_out = m_mstatus;
  assign mtvec_out   = m_mtvec;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] pc;
    logic        illegal;
    logic [3:0]  wen;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] seen_wen = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: accumulate write strobes, pop and compare on each response handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (csr_wen != 4'b0000) seen_wen = seen_wen | csr_wen;
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_rdata"},    resp_rdata,           e.rdata);
            chk({e.name, "_redirect"}, 32'(resp_redirect),   32'(e.redirect));
            chk({e.name, "_pc"},       resp_pc,              e.pc);
            chk({e.name, "_illegal"},  32'(resp_illegal),    32'(e.illegal));
            chk({e.name, "_wen"},      32'(seen_wen),        32'(e.wen));
          end
          seen_wen = 4'b0000;
        end
      end
    end
  end

  // Issue one request from posedge+1; checks csr_wen in the EXEC cycle (N+1)
  task automatic issue(input string name, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc, input logic push,
                       input logic [31:0] e_rdata, input logic e_redir, input logic [31:0] e_pc,
                       input logic e_ill, input logic [3:0] e_wen);
    int t;
    exp_t e;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    if (push) begin
      e.name = name; e.rdata = e_rdata; e.redirect = e_redir; e.pc = e_pc;
      e.illegal = e_ill; e.wen = e_wen;
      sb.push_back(e);
    end
    req_valid = 1'b1; req_op = op; req_csr_addr = addr; req_wdata = wd; req_pc = pc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, "_wen_exec"}, 32'(csr_wen), 32'(e_wen));
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (sb.size() != 0 || !req_ready) chk({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_csr_addr = '0;
    req_wdata = '0; req_pc = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),     32'd1);
    chk("rst_resp_valid", 32'(resp_valid),    32'd0);
    chk("rst_wen",        32'(csr_wen),       32'd0);
    chk("rst_rdata",      resp_rdata,         32'd0);
    chk("rst_redirect",   32'(resp_redirect), 32'd0);
    chk("rst_pc",         resp_pc,            32'd0);
    chk("rst_illegal",    32'(resp_illegal),  32'd0);
    chk("rst_mstatus_in", mstatus_in,         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'b1000);
    wait_done("rw_mtvec");
    chk("mtvec_after_rw", m_mtvec, 32'h8000_0100);

    issue("ecall", 3'd3, 12'h000, 32'h0, 32'h8000_0040, 1'b1, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 4'b0111);
    wait_done("ecall");
    chk("ecall_mepc",    m_mepc,    32'h8000_0040);
    chk("ecall_mcause",  m_mcause,  32'd11);
    chk("ecall_mstatus", m_mstatus, 32'h0000_1880);

    issue("mret", 3'd5, 12'h000, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h8000_0040, 1'b0, 4'b0100);
    wait_done("mret");
    chk("mret_mstatus", m_mstatus, 32'h0000_1888);

    issue("rs_zero", 3'd1, 12'h300, 32'h0, 32'h0, 1'b1, 32'h0000_1888, 1'b0, 32'h0, 1'b0, 4'b0000);
    wait_done("rs_zero");
    chk("rs_zero_mstatus", m_mstatus, 32'h0000_1888);

    issue("rc_mie", 3'd2, 12'h300, 32'h8, 32'h0, 1'b1, 32'h0000_1888, 1'b0, 32'h0, 1'b0, 4'b0100);
    wait_done("rc_mie");
    chk("rc_mie_mstatus", m_mstatus, 32'h0000_1880);

    issue("ebreak", 3'd4, 12'h000, 32'h0, 32'h8000_0083, 1'b1, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 4'b0111);
    wait_done("ebreak");
    chk("ebreak_mepc",    m_mepc,    32'h8000_0080);
    chk("ebreak_mcause",  m_mcause,  32'd3);
    chk("ebreak_mstatus", m_mstatus, 32'h0000_1800);

    issue("rw_mepc", 3'd0, 12'h341, 32'h0000_1237, 32'h0, 1'b1, 32'h8000_0080, 1'b0, 32'h0, 1'b0, 4'b0001);
    wait_done("rw_mepc");
    chk("rw_mepc_align", m_mepc, 32'h0000_1234);

    issue("rs_mcause", 3'd1, 12'h342, 32'h10, 32'h0, 1'b1, 32'h3, 1'b0, 32'h0, 1'b0, 4'b0010);
    wait_done("rs_mcause");
    chk("rs_mcause_val", m_mcause, 32'h13);

    issue("ill_addr", 3'd0, 12'h7C0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 4'b0000);
    wait_done("ill_addr");

    // Back-pressure: response must hold while resp_ready is low
    resp_ready = 1'b0;
    issue("ill_op7", 3'd7, 12'h300, 32'h1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 4'b0000);
    begin
      int t;
      t = 0;
      while (!resp_valid && t < 20) begin
        @(posedge clk); #1; t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", 32'(resp_valid),   32'd1);
      chk("hold_illegal",    32'(resp_illegal), 32'd1);
      chk("hold_rdata",      resp_rdata,        32'd0);
      chk("hold_req_ready",  32'(req_ready),    32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    wait_done("ill_op7");
    chk("ill_mstatus_kept", m_mstatus, 32'h0000_1800);

    // Reset during EXEC aborts the write immediately
    issue("rst_exec", 3'd0, 12'h305, 32'hDEAD_BEE0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'b1000);
    #1 rst = 1'b1;
    #1;
    chk("rst_exec_wen",        32'(csr_wen),    32'd0);
    chk("rst_exec_req_ready",  32'(req_ready),  32'd1);
    chk("rst_exec_resp_valid", 32'(resp_valid), 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec_mtvec", m_mtvec, 32'h8000_0100);
    chk("rst_exec_idle",  32'(resp_valid), 32'd0);

    // Sequencer still usable after the abort
    issue("after_rst", 3'd1, 12'h305, 32'h0, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 4'b0000);
    wait_done("after_rst");

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
